// File: rtl/flash_loader.sv
// Boot-time copier: issues one continuous SPI READ (0x03) to the configuration
// flash and writes every received byte to consecutive SRAM addresses.
module flash_loader #(
  parameter logic [23:0] FLASH_OFFSET = 24'h013256,
  parameter int          LENGTH       = 131072,
  parameter logic [16:0] RAM_BASE     = 17'h00000,
  parameter int          SCK_DIV      = 2,
  parameter int          WR_CYCLES    = 2
) (
  input  logic        clk28,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        flash_cs_n,
  output logic        flash_sck,
  output logic        flash_mosi,
  input  logic        flash_miso,
  output logic [16:0] ram_addr,
  output logic [7:0]  ram_data,
  output logic        ram_wren
);

  localparam logic [31:0] CMD_WORD = {8'h03, FLASH_OFFSET};
  localparam logic [7:0]  DIV_LAST = 8'(SCK_DIV - 1);
  localparam logic [3:0]  WR_LAST  = 4'(WR_CYCLES - 1);
  localparam logic [17:0] LEN_LAST = 18'(LENGTH - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, CMDADDR, DATA, WRITE, FINISH
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  wr_cnt_q, wr_cnt_d;
  logic [17:0] byte_cnt_q, byte_cnt_d;
  logic [30:0] shift_q, shift_d;
  logic [7:0]  rx_q, rx_d;
  logic        sck_q, sck_d;
  logic        cs_n_q, cs_n_d;
  logic        mosi_q, mosi_d;
  logic        wren_q, wren_d;
  logic [16:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        tick;

  assign tick = (div_q == DIV_LAST);

  // start is a one-cycle request honoured only in IDLE; there is no ready,
  // so a request seen in any other state is dropped.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_cnt_d  = bit_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    rx_d       = rx_q;
    sck_d      = sck_q;
    cs_n_d     = cs_n_q;
    mosi_d     = mosi_q;
    wren_d     = wren_q;
    addr_d     = addr_q;
    data_d     = data_q;
    busy_d     = busy_q;
    done_d     = done_q;

    if (state_q == SETUP || state_q == CMDADDR || state_q == DATA || state_q == FINISH) begin
      div_d = tick ? 8'd0 : div_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SETUP;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          cs_n_d     = 1'b0;
          mosi_d     = CMD_WORD[31];
          shift_d    = CMD_WORD[30:0];
          byte_cnt_d = '0;
          bit_cnt_d  = '0;
          addr_d     = RAM_BASE;
          div_d      = '0;
        end
      end
      SETUP: begin
        if (tick) state_d = CMDADDR;
      end
      CMDADDR: begin
        if (tick) begin
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            sck_d   = 1'b0;
            shift_d = {shift_q[29:0], 1'b0};
            if (bit_cnt_q == 6'd31) begin
              mosi_d    = 1'b0;
              bit_cnt_d = '0;
              state_d   = DATA;
            end else begin
              mosi_d    = shift_q[30];
              bit_cnt_d = bit_cnt_q + 6'd1;
            end
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (!sck_q) begin
            sck_d     = 1'b1;
            rx_d      = {rx_q[6:0], flash_miso};
            bit_cnt_d = bit_cnt_q + 6'd1;
          end else begin
            sck_d = 1'b0;
            if (bit_cnt_q == 6'd8) begin
              data_d   = rx_q;
              wren_d   = 1'b1;
              wr_cnt_d = '0;
              state_d  = WRITE;
            end
          end
        end
      end
      WRITE: begin
        // SCK parked low and cs_n held low: the flash read simply pauses.
        if (wr_cnt_q == WR_LAST) begin
          wren_d     = 1'b0;
          byte_cnt_d = byte_cnt_q + 18'd1;
          div_d      = '0;
          if (byte_cnt_q == LEN_LAST) begin
            cs_n_d  = 1'b1;
            state_d = FINISH;
          end else begin
            addr_d    = addr_q + 17'd1;
            bit_cnt_d = '0;
            state_d   = DATA;
          end
        end else begin
          wr_cnt_d = wr_cnt_q + 4'd1;
        end
      end
      FINISH: begin
        if (tick) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_cnt_q  <= '0;
      wr_cnt_q   <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      rx_q       <= '0;
      sck_q      <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      wren_q     <= 1'b0;
      addr_q     <= RAM_BASE;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      rx_q       <= rx_d;
      sck_q      <= sck_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
      wren_q     <= wren_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign flash_cs_n = cs_n_q;
  assign flash_sck  = sck_q;
  assign flash_mosi = mosi_q;
  assign ram_addr   = addr_q;
  assign ram_data   = data_q;
  assign ram_wren   = wren_q;

endmodule

// File: doc/flash_loader.md
Name: flash_loader

Overview:
- Boot-time copier that streams a ROM image from the configuration SPI flash into external SRAM.
- Sits upstream of the memory controller. It drives the SRAM write path (address, data, write strobe) while busy is high; the memory controller muxes these onto the video address/data bus ahead of all other requests.
- Issues one continuous SPI READ (0x03) and writes each received byte to consecutive SRAM addresses.

Parameters:
- FLASH_OFFSET, 24'h013256, flash byte address of the first image byte.
- LENGTH, 131072, number of bytes to copy; legal range 1..131072.
- RAM_BASE, 17'h00000, SRAM address of the first written byte.
- SCK_DIV, 2, clk28 cycles per SCK half-period; legal range 1..255.
- WR_CYCLES, 2, clk28 cycles ram_wren is held per byte; legal range 1..15.

Ports:
- clk28  in  1  system clock, 28 MHz.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle request to begin a copy.
- busy  out  1  high from the cycle after an accepted start until the copy completes.
- done  out  1  high after a completed copy; cleared by the next accepted start or by rst.
- flash_cs_n  out  1  SPI chip select, active low.
- flash_sck  out  1  SPI clock, mode 0, idles low.
- flash_mosi  out  1  SPI data to flash.
- flash_miso  in  1  SPI data from flash.
- ram_addr  out  17  SRAM write address.
- ram_data  out  8  SRAM write data.
- ram_wren  out  1  SRAM write strobe, active high.

Behaviour:
- Clock and reset: one clock, clk28. Reset rst is asynchronous and active-high.
- Outputs while rst is high (asserted immediately, even mid-copy, with no flash or RAM cleanup):
  - flash_cs_n=1, flash_sck=0, flash_mosi=0.
  - ram_wren=0, ram_addr=RAM_BASE, ram_data=0.
  - busy=0, done=0.
  - FSM returns to IDLE.
- Bit timing: a divider counter produces a tick every SCK_DIV cycles; flash_sck toggles on each tick while shifting.
  - MOSI updates while SCK is low, before its rising edge.
  - MISO is sampled on the clk28 edge where SCK goes 0->1.
  - One SPI bit = 2*SCK_DIV clk28 cycles. All shifts are MSB first.
- FSM states:
  - IDLE: start=1 -> busy=1, done=0, cs_n=0, load shifter {8'h03, FLASH_OFFSET}, byte counter=0, ram_addr=RAM_BASE; go to SETUP. start=0 -> stay.
  - SETUP: one SCK half-period with cs_n low, SCK low, MOSI = bit 31 (tCSS margin); then go to CMDADDR.
  - CMDADDR: shift 32 bits out. After the falling SCK edge of bit 0, go to DATA. MOSI is driven 0 for the remainder of the transfer.
  - DATA: 8 SCK pulses, sampling MISO into the receive shifter. After the 8th rising edge, SCK returns low on the next tick; then ram_data=byte, ram_wren=1, go to WRITE.
  - WRITE:
    - Hold ram_wren=1 with addr/data stable for WR_CYCLES cycles, then ram_wren=0.
    - Count the byte. If the count equals LENGTH, go to FINISH. Otherwise ram_addr+1 and return to DATA.
    - SCK stays low and cs_n stays low during WRITE; the flash continuous read simply pauses.
  - FINISH: cs_n=1 for one SCK half-period, then busy=0, done=1, go to IDLE.
- ram_addr is 17 bits and wraps 17'h1FFFF -> 17'h00000. The byte counter is 18 bits, so LENGTH=131072 is exact.
- start while busy=1 is ignored. start in the same cycle that FINISH exits is ignored. start in IDLE with done=1 begins a new copy.
- ram_addr and ram_data never change while ram_wren=1.
- Exactly LENGTH write pulses per copy; no write pulse occurs outside busy.
- Cycle count per copy: SCK_DIV*(1 + 64 + 16*LENGTH + 1) + WR_CYCLES*LENGTH + the byte-completion ticks. The exact value is fixed by the RTL and must be constant for given parameters.

Test Plan:
- Basic copy (SCK_DIV=2, LENGTH=4, flash model returns A5,5A,00,FF):
  - MOSI stream is 0x03, 0x01, 0x32, 0x56.
  - Four ram_wren pulses of 2 cycles each, at addr 0..3 with data A5,5A,00,FF.
  - done=1, busy=0, cs_n=1 at the end.
- SPI timing check: assert SCK idles low; MOSI is stable on every rising SCK edge; cs_n=0 for the whole transfer, including WRITE gaps; SCK half-period is exactly SCK_DIV cycles.
- LENGTH=1, RAM_BASE=17'h1FFFF, two back-to-back copies: each writes once at 1FFFF; the second start clears done in IDLE and sets it again at the end.
- Wrap: RAM_BASE=17'h1FFFE, LENGTH=3 -> writes to 1FFFE, 1FFFF, 00000.
- start pulsed mid-DATA and again on the FINISH exit cycle -> ignored; exactly LENGTH writes occur.
- rst asserted during WRITE with ram_wren=1 -> same cycle: ram_wren=0, cs_n=1, busy=0, done=0. After rst is released, a new start performs a full correct copy.
